except_flush_ctrl: RTL and testbench

Sequences the pipeline response to an accepted exception or ERET request from the exception unit.
- Squashes younger instructions and holds issue.
- Drains outstanding data-bus transactions, with a bounded wait.
- Commits exception state to CP0 in a single strobe.
- Redirects fetch to the exception vector (or EPC) through a valid/ready handshake.
Sits between the exception unit, CP0, the data-bus interface and the fetch stage.

---
 rtl/except_pkg.sv | 30 +++
 rtl/except_flush_ctrl.sv | 117 +++++++++++
 tb/tb_except_flush_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/except_pkg.sv
// Shared types for the exception flush sequencer.
// ExcCode values used by the exception unit and CP0.
package except_pkg;

    localparam int DRAIN_TIMEOUT_DEFAULT = 64;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } flush_state_t;

    typedef struct packed {
        logic        eret;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        delayslot;
        logic [31:0] vec;
    } except_latch_t;

endpackage

// File: rtl/except_flush_ctrl.sv
// Exception/ERET flush sequencer: squash, drain data bus,
// commit to CP0, then redirect fetch.
module except_flush_ctrl
    import except_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    parameter int PEND_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              except_valid,
    input  logic              except_eret,
    input  logic [4:0]        except_code,
    input  logic [31:0]       except_pc,
    input  logic              except_delayslot,
    input  logic [31:0]       except_vec,
    input  logic [PEND_W-1:0] dbus_pending,
    output logic              flush,
    output logic              hold_issue,
    output logic              cp0_commit_valid,
    output logic              cp0_commit_eret,
    output logic [4:0]        cp0_commit_code,
    output logic [31:0]       cp0_commit_epc,
    output logic              cp0_commit_bd,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    input  logic              redirect_ready,
    output logic              drain_timeout,
    output logic              busy
);

    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    flush_state_t  state;
    flush_state_t  state_nxt;
    except_latch_t lat;
    logic [CNT_W-1:0] cnt;
    logic          to_q;
    logic          accept;
    logic          pend_zero;
    logic          to_hit;
    logic          redir_done;
    logic          commit_exc;

    assign accept     = (state == ST_IDLE) && except_valid;
    assign pend_zero  = (dbus_pending == '0);
    assign to_hit     = (state == ST_DRAIN) && !pend_zero && (cnt == CNT_LAST);
    assign redir_done = (state == ST_REDIRECT) && redirect_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (except_valid) state_nxt = pend_zero ? ST_COMMIT : ST_DRAIN;
            ST_DRAIN:    if (pend_zero || to_hit) state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured once; later requests are blocked by hold_issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat  <= '0;
            cnt  <= '0;
            to_q <= 1'b0;
        end else begin
            to_q <= to_hit;
            if (accept) begin
                lat <= '{eret:      except_eret,
                         code:      except_code,
                         pc:        except_pc,
                         delayslot: except_delayslot,
                         vec:       except_vec};
            end
            if (state == ST_DRAIN) begin
                cnt <= cnt + 1'b1;
            end else if (redir_done) begin
                cnt <= '0;
            end
        end
    end

    assign commit_exc = (state == ST_COMMIT) && !lat.eret;

    always_comb begin
        flush            = accept;
        busy             = (state != ST_IDLE);
        hold_issue       = (state != ST_IDLE);
        cp0_commit_valid = (state == ST_COMMIT);
        cp0_commit_eret  = (state == ST_COMMIT) && lat.eret;
        cp0_commit_code  = '0;
        cp0_commit_epc   = '0;
        cp0_commit_bd    = 1'b0;
        redirect_valid   = (state == ST_REDIRECT);
        redirect_pc      = '0;
        drain_timeout    = to_q;
        if (commit_exc) begin
            cp0_commit_code = lat.code;
            cp0_commit_epc  = lat.delayslot ? (lat.pc - 32'd4) : lat.pc;
            cp0_commit_bd   = lat.delayslot;
        end
        if (state == ST_REDIRECT) begin
            redirect_pc = lat.vec;
        end
    end

endmodule

// File: tb/tb_except_flush_ctrl.sv
// Directed bench for except_flush_ctrl: vector table plus
// hand-written drain, timeout and async-reset sequences.
module tb_except_flush_ctrl;

    typedef struct packed {
        logic        ev;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] vec;
        logic [3:0]  pend;
        logic        rdy;
    } in_t;

    typedef struct packed {
        logic        flush;
        logic        hold;
        logic        cv;
        logic        ceret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        rv;
        logic [31:0] rpc;
        logic        to;
        logic        busy;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        except_valid;
    logic        except_eret;
    logic [4:0]  except_code;
    logic [31:0] except_pc;
    logic        except_delayslot;
    logic [31:0] except_vec;
    logic [3:0]  dbus_pending;
    logic        flush;
    logic        hold_issue;
    logic        cp0_commit_valid;
    logic        cp0_commit_eret;
    logic [4:0]  cp0_commit_code;
    logic [31:0] cp0_commit_epc;
    logic        cp0_commit_bd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        drain_timeout;
    logic        busy;

    int checks;
    int failures;
    vec_t tbl[$];

    except_flush_ctrl #(
        .DRAIN_TIMEOUT(8),
        .PEND_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .except_valid(except_valid),
        .except_eret(except_eret),
        .except_code(except_code),
        .except_pc(except_pc),
        .except_delayslot(except_delayslot),
        .except_vec(except_vec),
        .dbus_pending(dbus_pending),
        .flush(flush),
        .hold_issue(hold_issue),
        .cp0_commit_valid(cp0_commit_valid),
        .cp0_commit_eret(cp0_commit_eret),
        .cp0_commit_code(cp0_commit_code),
        .cp0_commit_epc(cp0_commit_epc),
        .cp0_commit_bd(cp0_commit_bd),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready),
        .drain_timeout(drain_timeout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(logic ev, logic eret, logic [4:0] code,
                                  logic [31:0] pc, logic ds, logic [31:0] vec,
                                  logic [3:0] pend, logic rdy);
        in_t r;
        r.ev = ev; r.eret = eret; r.code = code; r.pc = pc;
        r.ds = ds; r.vec = vec; r.pend = pend; r.rdy = rdy;
        return r;
    endfunction

    function automatic in_t nop(logic [3:0] pend, logic rdy);
        return mk_in(1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 32'h0, pend, rdy);
    endfunction

    function automatic out_t o_idle(logic f);
        out_t o = '0;
        o.flush = f;
        return o;
    endfunction

    function automatic out_t o_drain();
        out_t o = '0;
        o.hold = 1'b1;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t o_commit(logic eret, logic [4:0] code,
                                      logic [31:0] epc, logic bd, logic to);
        out_t o = '0;
        o.hold = 1'b1; o.busy = 1'b1; o.cv = 1'b1;
        o.ceret = eret; o.code = code; o.epc = epc; o.bd = bd; o.to = to;
        return o;
    endfunction

    function automatic out_t o_redir(logic [31:0] pc);
        out_t o = '0;
        o.hold = 1'b1; o.busy = 1'b1; o.rv = 1'b1; o.rpc = pc;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.flush = flush; o.hold = hold_issue; o.cv = cp0_commit_valid;
        o.ceret = cp0_commit_eret; o.code = cp0_commit_code;
        o.epc = cp0_commit_epc; o.bd = cp0_commit_bd;
        o.rv = redirect_valid; o.rpc = redirect_pc;
        o.to = drain_timeout; o.busy = busy;
        return o;
    endfunction

    task automatic add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n; v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    task automatic apply(in_t i);
        except_valid     = i.ev;
        except_eret      = i.eret;
        except_code      = i.code;
        except_pc        = i.pc;
        except_delayslot = i.ds;
        except_vec       = i.vec;
        dbus_pending     = i.pend;
        redirect_ready   = i.rdy;
    endtask

    task automatic chk(string n, out_t exp);
        out_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    task automatic step(string n, in_t i, out_t exp);
        @(posedge clk);
        #1;
        apply(i);
        #2;
        chk(n, exp);
    endtask

    task automatic pulse_reset(string n);
        #1 rst_n = 1'b0;
        #1 chk(n, o_idle(1'b0));
        #1 rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        apply(nop(4'd0, 1'b0));
        #12;
        chk("reset_state", o_idle(1'b0));
        rst_n = 1'b1;

        add("t1_req", mk_in(1, 0, 5'h04, 32'h80001000, 0, 32'hBFC00380, 0, 0), o_idle(1));
        add("t1_commit", nop(0, 0), o_commit(0, 5'h04, 32'h80001000, 0, 0));
        add("t1_redir", nop(0, 1), o_redir(32'hBFC00380));
        add("t1_idle", nop(0, 0), o_idle(0));
        add("t2_req", mk_in(1, 0, 5'h05, 32'h80002004, 1, 32'hBFC00380, 0, 0), o_idle(1));
        add("t2_commit", nop(0, 0), o_commit(0, 5'h05, 32'h80002000, 1, 0));
        add("t2_redir", nop(0, 1), o_redir(32'hBFC00380));
        add("t2_idle", nop(0, 0), o_idle(0));
        add("pc0_req", mk_in(1, 0, 5'h0c, 32'h0, 1, 32'hBFC00200, 0, 0), o_idle(1));
        add("pc0_commit", nop(0, 0), o_commit(0, 5'h0c, 32'hFFFFFFFC, 1, 0));
        add("pc0_redir", nop(0, 1), o_redir(32'hBFC00200));
        add("pc0_idle", nop(0, 0), o_idle(0));
        add("eret_req", mk_in(1, 1, 5'h0a, 32'h00001234, 1, 32'h80000010, 0, 0), o_idle(1));
        add("eret_commit", nop(2, 0), o_commit(1, 5'h00, 32'h0, 0, 0));
        add("eret_stall0", nop(0, 0), o_redir(32'h80000010));
        add("eret_stall1", mk_in(1, 0, 5'h04, 32'h80009000, 0, 32'hBFC00380, 0, 0),
            o_redir(32'h80000010));
        add("eret_stall2", nop(3, 0), o_redir(32'h80000010));
        add("eret_stall3", nop(0, 0), o_redir(32'h80000010));
        add("eret_hshake", mk_in(1, 0, 5'h04, 32'h80009000, 0, 32'hBFC00380, 0, 1),
            o_redir(32'h80000010));
        add("eret_idle", nop(0, 0), o_idle(0));

        foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].o);

        // Drain releases after five cycles, no timeout.
        step("d_req", mk_in(1, 0, 5'h04, 32'h80003000, 0, 32'hBFC00380, 3, 0), o_idle(1));
        for (int k = 0; k < 4; k++) step("d_wait", nop(3, 0), o_drain());
        step("d_last", nop(0, 0), o_drain());
        step("d_commit", nop(0, 0), o_commit(0, 5'h04, 32'h80003000, 0, 0));
        step("d_redir", nop(0, 1), o_redir(32'hBFC00380));
        step("d_idle", nop(0, 0), o_idle(0));

        // Pending stuck: forced commit on the ninth cycle with a pulse.
        step("to_req", mk_in(1, 0, 5'h0c, 32'h80004000, 0, 32'hBFC00380, 1, 0), o_idle(1));
        for (int k = 0; k < 8; k++) step("to_wait", nop(1, 0), o_drain());
        step("to_commit", nop(1, 0), o_commit(0, 5'h0c, 32'h80004000, 0, 1));
        step("to_redir", nop(1, 1), o_redir(32'hBFC00380));
        step("to_idle", nop(0, 0), o_idle(0));

        // Pending clears on the last drain cycle: no pulse.
        step("tv_req", mk_in(1, 0, 5'h0c, 32'h80005000, 1, 32'hBFC00180, 1, 0), o_idle(1));
        for (int k = 0; k < 7; k++) step("tv_wait", nop(1, 0), o_drain());
        step("tv_last", nop(0, 0), o_drain());
        step("tv_commit", nop(0, 0), o_commit(0, 5'h0c, 32'h80004FFC, 1, 0));
        step("tv_redir", nop(0, 1), o_redir(32'hBFC00180));
        step("tv_idle", nop(0, 0), o_idle(0));

        // Async reset mid-DRAIN, then a normal request.
        step("r1_req", mk_in(1, 0, 5'h04, 32'h80006000, 0, 32'hBFC00380, 1, 0), o_idle(1));
        step("r1_drain0", nop(1, 0), o_drain());
        step("r1_drain1", nop(1, 0), o_drain());
        pulse_reset("r1_async");
        step("r1_after", mk_in(1, 0, 5'h05, 32'h80007000, 0, 32'hBFC00380, 0, 0), o_idle(1));
        step("r1_commit", nop(0, 0), o_commit(0, 5'h05, 32'h80007000, 0, 0));
        step("r1_redir", nop(0, 1), o_redir(32'hBFC00380));
        step("r1_idle", nop(0, 0), o_idle(0));

        // Async reset mid-REDIRECT, then a normal request.
        step("r2_req", mk_in(1, 0, 5'h08, 32'h80008000, 0, 32'hBFC00380, 0, 0), o_idle(1));
        step("r2_commit", nop(0, 0), o_commit(0, 5'h08, 32'h80008000, 0, 0));
        step("r2_redir", nop(0, 0), o_redir(32'hBFC00380));
        pulse_reset("r2_async");
        step("r2_after", mk_in(1, 0, 5'h09, 32'h8000A004, 1, 32'hBFC00300, 0, 0), o_idle(1));
        step("r2_commit2", nop(0, 0), o_commit(0, 5'h09, 32'h8000A000, 1, 0));
        step("r2_redir2", nop(0, 1), o_redir(32'hBFC00300));
        step("r2_idle", nop(0, 0), o_idle(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
